ss_addsub_ctrl: RTL and testbench

SS_ADDSUB_CTRL -- requirements
Module: ss_addsub_ctrl

---
 rtl/ss_ctrl_defs.sv | 14 +
 rtl/ss_updown_acc.sv | 32 +++
 rtl/ss_addsub_ctrl.sv | 103 ++++++++++
 tb/tb_ss_addsub_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ss_ctrl_defs.sv
// Constants shared by the stochastic-computing controllers: FSM encodings
// and the default window-counter width.
package ss_ctrl_defs;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/ss_updown_acc.sv
// Signed +1/-1/0 accumulator with synchronous clear. The next value is also
// exposed so the caller can capture a total that includes this cycle's step.
module ss_updown_acc #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         en,
    input  logic         dn,
    output logic [W-1:0] acc_reg,
    output logic [W-1:0] acc_next
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        acc_next = acc_reg;
        if (en) begin
            acc_next = dn ? acc_reg - ONE : acc_reg + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/ss_addsub_ctrl.sv
// Window controller for a stochastic add/sub datapath: counts signed output
// bits over WINDOW cycles and hands the sum to a consumer via valid/ready.
module ss_addsub_ctrl
    import ss_ctrl_defs::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             START,
    input  logic [CNT_W-1:0] WINDOW,
    input  logic             ABORT,
    input  logic             ADD_OUT,
    input  logic             ADD_SIGN,
    output logic             ADD_INIT,
    output logic             R_COND,
    output logic             BUSY,
    output logic [CNT_W:0]   RESULT,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY
);

    ctrl_state_t      state_reg;
    logic [CNT_W-1:0] ticks_reg;
    logic [CNT_W:0]   result_reg;
    logic             result_valid_reg;
    logic             r_cond_reg;
    logic [CNT_W:0]   acc_reg;
    logic [CNT_W:0]   acc_next;

    ss_updown_acc #(
        .W(CNT_W + 1)
    ) u_acc (
        .clk      (CLK),
        .srst     (INIT),
        .clr      (state_reg == ST_CLEAR),
        .en       ((state_reg == ST_RUN) && ADD_OUT),
        .dn       (ADD_SIGN),
        .acc_reg  (acc_reg),
        .acc_next (acc_next)
    );

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_reg        <= ST_IDLE;
            ticks_reg        <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            r_cond_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        ticks_reg <= WINDOW;
                        if (WINDOW == '0) begin
                            result_reg       <= '0;
                            result_valid_reg <= 1'b1;
                            state_reg        <= ST_DONE;
                        end else begin
                            state_reg <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_cond_reg <= 1'b0;
                    state_reg  <= ABORT ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (ABORT) begin
                        r_cond_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        ticks_reg <= ticks_reg - CNT_W'(1);
                        if (ticks_reg == CNT_W'(1)) begin
                            // Capture includes the final RUN cycle's step.
                            result_reg       <= acc_next;
                            result_valid_reg <= 1'b1;
                            r_cond_reg       <= 1'b0;
                            state_reg        <= ST_DONE;
                        end else begin
                            r_cond_reg <= ~r_cond_reg;
                        end
                    end
                end
                ST_DONE: begin
                    if (ABORT || RESULT_READY) begin
                        result_valid_reg <= 1'b0;
                        state_reg        <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The datapath clears together with the controller during INIT.
    assign ADD_INIT     = INIT || (state_reg == ST_CLEAR);
    assign R_COND       = r_cond_reg;
    assign BUSY         = (state_reg != ST_IDLE);
    assign RESULT       = result_reg;
    assign RESULT_VALID = result_valid_reg;

endmodule

// File: tb/tb_ss_addsub_ctrl.sv
// Directed bench for ss_addsub_ctrl with hand-computed expected values.
module tb_ss_addsub_ctrl;

    logic       CLK = 1'b0;
    logic       INIT = 1'b1;
    logic       START = 1'b0;
    logic [7:0] WINDOW = 8'd0;
    logic       ABORT = 1'b0;
    logic       ADD_OUT = 1'b0;
    logic       ADD_SIGN = 1'b0;
    logic       ADD_INIT;
    logic       R_COND;
    logic       BUSY;
    logic [8:0] RESULT;
    logic       RESULT_VALID;
    logic       RESULT_READY = 1'b0;

    int errors = 0;
    int checks = 0;

    ss_addsub_ctrl #(.CNT_W(8)) dut (
        .CLK          (CLK),
        .INIT         (INIT),
        .START        (START),
        .WINDOW       (WINDOW),
        .ABORT        (ABORT),
        .ADD_OUT      (ADD_OUT),
        .ADD_SIGN     (ADD_SIGN),
        .ADD_INIT     (ADD_INIT),
        .R_COND       (R_COND),
        .BUSY         (BUSY),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_READY (RESULT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [5:0] sign_pat;
        int n;
        sign_pat = 6'b110111;  // bit k = ADD_SIGN on RUN cycle k+1: 1,1,1,0,1,1

        // Reset
        #1;
        check("init_add_init", 32'(ADD_INIT), 32'd1);
        tick();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_valid", 32'(RESULT_VALID), 32'd0);
        check("rst_result", 32'(RESULT), 32'd0);
        check("rst_rcond", 32'(R_COND), 32'd0);
        INIT = 1'b0;
        tick();
        check("idle_add_init", 32'(ADD_INIT), 32'd0);

        // WINDOW=4, all +1
        START = 1'b1; WINDOW = 8'd4; ADD_OUT = 1'b1; ADD_SIGN = 1'b0;
        tick();
        START = 1'b0;
        check("w4_clear_add_init", 32'(ADD_INIT), 32'd1);
        check("w4_clear_rcond", 32'(R_COND), 32'd0);
        check("w4_clear_busy", 32'(BUSY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("w4_run_rcond", 32'(R_COND), 32'(i % 2));
            check("w4_run_add_init", 32'(ADD_INIT), 32'd0);
            check("w4_run_valid", 32'(RESULT_VALID), 32'd0);
        end
        tick();
        check("w4_valid", 32'(RESULT_VALID), 32'd1);
        check("w4_result", 32'(RESULT), 32'h004);
        check("w4_done_rcond", 32'(R_COND), 32'd0);
        $display("tb: window=4 result=%0h valid=%0b", RESULT, RESULT_VALID);
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;
        check("w4_handshake_valid", 32'(RESULT_VALID), 32'd0);
        check("w4_handshake_busy", 32'(BUSY), 32'd0);

        // WINDOW=6, signs 1,1,1,0,1,1 -> -4
        START = 1'b1; WINDOW = 8'd6;
        tick();
        START = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            ADD_SIGN = sign_pat[k];
            tick();
        end
        check("w6_valid", 32'(RESULT_VALID), 32'd1);
        check("w6_result", 32'(RESULT), 32'h1FC);
        $display("tb: window=6 result=%0h valid=%0b", RESULT, RESULT_VALID);
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;

        // WINDOW=3, ADD_OUT 0,1,0 with +sign -> +1
        START = 1'b1; WINDOW = 8'd3; ADD_SIGN = 1'b0;
        tick();
        START = 1'b0;
        tick();
        ADD_OUT = 1'b0; tick();
        ADD_OUT = 1'b1; tick();
        ADD_OUT = 1'b0; tick();
        check("w3_result", 32'(RESULT), 32'h001);
        $display("tb: window=3 result=%0h valid=%0b", RESULT, RESULT_VALID);
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;

        // WINDOW=0 -> DONE directly, result 0, no clear pulse
        START = 1'b1; WINDOW = 8'd0;
        tick();
        START = 1'b0;
        check("w0_valid", 32'(RESULT_VALID), 32'd1);
        check("w0_result", 32'(RESULT), 32'h000);
        check("w0_add_init", 32'(ADD_INIT), 32'd0);
        $display("tb: window=0 result=%0h valid=%0b", RESULT, RESULT_VALID);
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;

        // WINDOW=255, all -1 -> -255, then hold with READY low
        START = 1'b1; WINDOW = 8'd255; ADD_OUT = 1'b1; ADD_SIGN = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (!RESULT_VALID && n < 400) begin
            tick();
            n++;
        end
        check("w255_latency", 32'(n), 32'd256);
        check("w255_result", 32'(RESULT), 32'h101);
        $display("tb: window=255 result=%0h valid=%0b", RESULT, RESULT_VALID);
        for (int c = 0; c < 10; c++) begin
            START = (c == 3);
            WINDOW = 8'd5;
            tick();
            check("w255_hold_valid", 32'(RESULT_VALID), 32'd1);
            check("w255_hold_result", 32'(RESULT), 32'h101);
        end
        START = 1'b0;
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;
        check("w255_release_valid", 32'(RESULT_VALID), 32'd0);
        tick();
        check("w255_start_ignored", 32'(BUSY), 32'd0);

        // ABORT on RUN cycle 3 of WINDOW=8, then an immediate new window
        START = 1'b1; WINDOW = 8'd8; ADD_SIGN = 1'b0;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        check("abort_run3_rcond", 32'(R_COND), 32'd0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_valid", 32'(RESULT_VALID), 32'd0);
        check("abort_result_kept", 32'(RESULT), 32'h101);
        $display("tb: window=8 aborted busy=%0b valid=%0b", BUSY, RESULT_VALID);
        START = 1'b1; WINDOW = 8'd2;
        tick();
        START = 1'b0;
        check("restart_busy", 32'(BUSY), 32'd1);
        tick(); tick(); tick();
        check("restart_valid", 32'(RESULT_VALID), 32'd1);
        check("restart_result", 32'(RESULT), 32'h002);
        $display("tb: window=2 result=%0h valid=%0b", RESULT, RESULT_VALID);
        RESULT_READY = 1'b1;
        tick();
        RESULT_READY = 1'b0;

        // INIT mid-RUN
        START = 1'b1; WINDOW = 8'd5;
        tick();
        START = 1'b0;
        tick(); tick();
        check("midrun_rcond", 32'(R_COND), 32'd1);
        INIT = 1'b1;
        #1;
        check("midrun_init_add_init", 32'(ADD_INIT), 32'd1);
        tick();
        check("midrun_rst_busy", 32'(BUSY), 32'd0);
        check("midrun_rst_result", 32'(RESULT), 32'h000);
        check("midrun_rst_valid", 32'(RESULT_VALID), 32'd0);
        check("midrun_rst_rcond", 32'(R_COND), 32'd0);
        check("midrun_hold_add_init", 32'(ADD_INIT), 32'd1);
        INIT = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("post_init_valid", 32'(RESULT_VALID), 32'd0);
        end
        check("post_init_add_init", 32'(ADD_INIT), 32'd0);
        $display("tb: init mid-run busy=%0b valid=%0b", BUSY, RESULT_VALID);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
